// File: rtl/cu_pkg.sv
// Shared definitions for the streaming compute unit: state encoding and
// width derivation helpers.
package cu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        FILL   = 2'd2,
        RUN    = 2'd3
    } cu_state_e;

    function automatic int cu_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Accumulator wide enough for K*K full-scale signed products.
    function automatic int cu_aw(input int k, input int dw);
        return 2 * dw + cu_clog2(k * k);
    endfunction

endpackage

// File: rtl/cu_mac_tree.sv
// Combinational KxK signed multiply and reduction of weights against the
// current window into a full-precision sum.
module cu_mac_tree
    import cu_pkg::*;
#(
    parameter int K  = 3,
    parameter int DW = 8,
    localparam int AW = cu_aw(K, DW)
) (
    input  logic [K*K*DW-1:0] weights,
    input  logic [K*K*DW-1:0] window,
    output logic signed [AW-1:0] sum
);

    logic signed [2*DW-1:0] prod [K*K];

    always_comb begin
        sum = '0;
        for (int i = 0; i < K * K; i++) begin
            prod[i] = $signed(weights[i*DW +: DW]) * $signed(window[i*DW +: DW]);
            sum     = sum + AW'(prod[i]);
        end
    end

endmodule

// File: rtl/cu_stream_engine.sv
// Streaming KxK compute unit: serial kernel load, sliding column window and
// one registered MAC result per completed window. Build option
// CU_STREAM_RELU_EN clamps negative results to zero.
//
// state  | meaning
// IDLE   | no valid kernel, waiting for tap 0
// LOAD_W | receiving remaining kernel taps
// FILL   | kernel valid, fewer than K columns in the window
// RUN    | window full, every accepted column yields a result
module cu_stream_engine
    import cu_pkg::*;
#(
    parameter int K  = 3,
    parameter int DW = 8,
    localparam int AW = cu_aw(K, DW)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              soft_clr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DW-1:0]     w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K*DW-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_data,
    output logic              busy
);

    localparam int NT = K * K;
    localparam int TW = cu_clog2(NT);
    localparam int CW = cu_clog2(K);

    cu_state_e          state, state_nxt;
    logic               rdy_en;
    logic [TW-1:0]      tap_cnt;
    logic [CW-1:0]      col_cnt;
    logic [NT*DW-1:0]   weights;
    logic [NT*DW-1:0]   window;
    logic [NT*DW-1:0]   win_shift;
    logic signed [AW-1:0] sum;
    logic [AW-1:0]      result;
    logic               w_acc;
    logic               col_acc;
    logic               col_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        in_ready  = 1'b0;
        w_acc     = 1'b0;
        col_acc   = 1'b0;
        col_done  = 1'b0;
        case (state)
            IDLE: begin
                w_ready = rdy_en;
                w_acc   = w_valid && rdy_en;
                if (w_acc) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                w_acc   = w_valid;
                if (w_acc && tap_cnt == TW'(NT - 1)) state_nxt = FILL;
            end
            FILL, RUN: begin
                in_ready = !out_valid || out_ready;
                col_acc  = in_valid && in_ready;
                col_done = col_acc && (state == RUN || col_cnt == CW'(K - 1));
                if (col_acc) begin
                    if (in_last)       state_nxt = FILL;
                    else if (col_done) state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Clear takes priority over any handshake in the same cycle.
        if (soft_clr) begin
            state_nxt = IDLE;
            w_acc     = 1'b0;
            col_acc   = 1'b0;
            col_done  = 1'b0;
        end
    end

    assign busy = (state != IDLE);

    // Window as it looks after the incoming column: oldest dropped at c=0.
    always_comb begin
        win_shift = window;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                win_shift[(r*K+c)*DW +: DW] = window[(r*K+c+1)*DW +: DW];
            win_shift[(r*K+K-1)*DW +: DW] = in_data[r*DW +: DW];
        end
    end

    cu_mac_tree #(.K(K), .DW(DW)) u_mac (
        .weights (weights),
        .window  (win_shift),
        .sum     (sum)
    );

`ifdef CU_STREAM_RELU_EN
    assign result = sum[AW-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdy_en    <= 1'b0;
            tap_cnt   <= '0;
            col_cnt   <= '0;
            weights   <= '0;
            window    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (soft_clr) begin
            rdy_en    <= 1'b1;
            tap_cnt   <= '0;
            col_cnt   <= '0;
            weights   <= '0;
            window    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (w_acc) begin
                for (int i = 0; i < NT; i++)
                    if (tap_cnt == TW'(i)) weights[i*DW +: DW] <= w_data;
                tap_cnt <= (tap_cnt == TW'(NT - 1)) ? '0 : tap_cnt + TW'(1);
            end
            if (col_acc) begin
                if (in_last) begin
                    window  <= '0;
                    col_cnt <= '0;
                end else begin
                    window <= win_shift;
                    if (col_cnt != CW'(K - 1)) col_cnt <= col_cnt + CW'(1);
                end
            end
            if (col_done) begin
                out_valid <= 1'b1;
                out_data  <= result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cu_stream_engine.sv
// Bench for cu_stream_engine: directed steps followed by randomized traffic,
// all checked against a column-queue reference model.
module tb_cu_stream_engine;
    import cu_pkg::*;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int NT = K * K;
    localparam int AW = cu_aw(K, DW);

    typedef int col_t [K];

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic soft_clr = 1'b0;
    logic w_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic in_valid = 1'b0;
    logic [K*DW-1:0] in_data = '0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic w_ready, in_ready, out_valid, busy;
    logic [AW-1:0] out_data;

    cu_stream_engine #(.K(K), .DW(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .soft_clr  (soft_clr),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: kernel taps, columns of the current row, pending result.
    int     mw [NT];
    int     wcnt;
    bit     up;
    col_t   cq [$];
    bit     ev;
    longint ed;

    bit     snap_valid, snap_in_ready, snap_busy;
    longint snap_data;
    bit     acc_w, acc_c;

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint relu(input longint s);
`ifdef CU_STREAM_RELU_EN
        return (s < 0) ? 0 : s;
`else
        return s;
`endif
    endfunction

    task automatic reset_model();
        wcnt = 0;
        cq.delete();
        ev = 1'b0;
        ed = 0;
        up = 1'b0;
    endtask

    task automatic set_col(input col_t v);
        for (int r = 0; r < K; r++) in_data[r*DW +: DW] = DW'(v[r]);
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit exp_wr, exp_ir;
        col_t nc;
        longint s;
        @(negedge clk);
        if (!nrst) reset_model();
        exp_wr = up && nrst && (wcnt < NT);
        exp_ir = nrst && (wcnt == NT) && (!ev || out_ready);
        chk("w_ready", w_ready, exp_wr);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, (nrst && wcnt > 0));
        if (ev || !nrst) chk("out_data", $signed(out_data), ed);
        snap_valid    = out_valid;
        snap_in_ready = in_ready;
        snap_busy     = busy;
        snap_data     = longint'($signed(out_data));
        acc_w = nrst && !soft_clr && w_valid && exp_wr;
        acc_c = nrst && !soft_clr && in_valid && exp_ir;
        @(posedge clk);
        if (!nrst) begin
            reset_model();
        end else if (soft_clr) begin
            wcnt = 0;
            cq.delete();
            ev = 1'b0;
            up = 1'b1;
        end else begin
            if (acc_w) begin
                mw[wcnt] = int'($signed(w_data));
                wcnt++;
            end
            if (acc_c) begin
                for (int r = 0; r < K; r++) nc[r] = int'($signed(in_data[r*DW +: DW]));
                cq.push_back(nc);
                if (cq.size() > K) void'(cq.pop_front());
                if (cq.size() == K) begin
                    s = 0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            s += longint'(mw[r*K+c]) * longint'(cq[c][r]);
                    ev = 1'b1;
                    ed = relu(s);
                end else if (out_ready) begin
                    ev = 1'b0;
                end
                if (in_last) cq.delete();
            end else if (out_ready) begin
                ev = 1'b0;
            end
            up = 1'b1;
        end
        #1;
    endtask

    task automatic send_w(input int v);
        int n;
        n = 0;
        w_valid = 1'b1;
        w_data  = DW'(v);
        do begin
            tick();
            n++;
        end while (!acc_w && n < 20);
        if (!acc_w) chk("w_timeout", n, -1);
        w_valid = 1'b0;
    endtask

    task automatic send_col(input col_t v, input bit last, output int n);
        n = 0;
        in_valid = 1'b1;
        in_last  = last;
        set_col(v);
        do begin
            tick();
            n++;
        end while (!acc_c && n < 30);
        if (!acc_c) chk("col_timeout", n, -1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int n;
        int px;
        longint big;
        col_t rc;
        reset_model();

        // Reset values
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Identity-diagonal kernel
        for (int i = 0; i < NT; i++) send_w((i % 4 == 0) ? 1 : 0);
        tick();
        chk("busy_loaded", snap_busy, 1);

        out_ready = 1'b1;
        send_col('{1, 2, 3}, 1'b0, n);
        send_col('{4, 5, 6}, 1'b0, n);
        send_col('{7, 8, 9}, 1'b0, n);
        tick();
        chk("res15_valid", snap_valid, 1);
        chk("res15", snap_data, 15);

        send_col('{10, 11, 12}, 1'b0, n);
        chk("stream_lat", n, 1);
        tick();
        chk("res24", snap_data, 24);
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < K; r++) rc[r] = $urandom_range(0, 255) - 128;
            send_col(rc, 1'b0, n);
            chk("stream_back2back", n, 1);
        end

        // Backpressure with a full window
        send_col('{1, 2, 3}, 1'b0, n);
        send_col('{4, 5, 6}, 1'b0, n);
        send_col('{7, 8, 9}, 1'b0, n);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_col('{20, 21, 22});
        repeat (5) begin
            tick();
            chk("bp_in_ready", snap_in_ready, 0);
            chk("bp_hold", snap_data, 15);
        end
        out_ready = 1'b1;
        send_col('{20, 21, 22}, 1'b0, n);
        chk("bp_release_lat", n, 1);
        tick();
        chk("bp_next", snap_data, 4 + 8 + 22);

        // Row boundary
        send_col('{2, 2, 2}, 1'b1, n);
        send_col('{1, 1, 1}, 1'b0, n);
        send_col('{1, 1, 1}, 1'b0, n);
        tick();
        chk("row_gap_valid", snap_valid, 0);
        send_col('{1, 1, 1}, 1'b0, n);
        tick();
        chk("row_first_valid", snap_valid, 1);
        chk("row_first", snap_data, 3);

        // Full-scale corner
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        tick();
        chk("clr_busy", snap_busy, 0);
        for (int i = 0; i < NT; i++) send_w(-128);
`ifdef CU_STREAM_RELU_EN
        px = 127;
        big = 0;
`else
        px = -128;
        big = 147456;
`endif
        for (int i = 0; i < K; i++) send_col('{px, px, px}, 1'b0, n);
        tick();
        chk("fullscale", snap_data, big);

        // Soft clear mid-RUN with a result pending
        out_ready = 1'b0;
        send_col('{px, px, px}, 1'b0, n);
        soft_clr = 1'b1;
        in_valid = 1'b1;
        tick();
        soft_clr = 1'b0;
        tick();
        chk("clr_out_valid", snap_valid, 0);
        chk("clr_busy2", snap_busy, 0);
        chk("clr_in_ready", snap_in_ready, 0);
        repeat (3) tick();
        in_valid = 1'b0;

        // Randomized traffic including reloads after random clears
        for (int i = 0; i < NT; i++) send_w($urandom_range(0, 255) - 128);
        for (int cyc = 0; cyc < 600; cyc++) begin
            w_valid   = ($urandom_range(0, 1) == 1);
            w_data    = DW'($urandom_range(0, 255));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            soft_clr  = ($urandom_range(0, 99) == 0);
            in_data   = (K*DW)'({$urandom, $urandom});
            tick();
        end
        soft_clr = 1'b0;
        w_valid  = 1'b0;

        // Asynchronous reset mid-operation
        in_valid  = 1'b1;
        out_ready = 1'b0;
        nrst      = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_w_ready", w_ready, 0);
        repeat (2) tick();
        in_valid = 1'b0;
        nrst = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
